// File: rtl/conv_cin_tile_accu_pkg.sv
// Shared types and helpers for the channel-tiled 3x3 convolution accumulator.
package conv_cin_tile_accu_pkg;

  // Tile sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-half-up arithmetic shift, saturate to a signed ow-bit range, optional ReLU.
  // Works at 64 bits so callers of any width up to 64 can sign-extend into it
  // and truncate the result back to their output width.
  function automatic logic signed [63:0] round_sat(
    input logic signed [63:0] v,
    input logic        [4:0]  shift,
    input int                 ow,
    input logic               relu_en
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = v;
    if (shift != 5'd0) r = r + (64'sd1 <<< (shift - 5'd1));
    r  = r >>> shift;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    if (relu_en && (r < 64'sd0)) r = 64'sd0;
    return r;
  endfunction

endpackage

// File: rtl/conv_cin_tile_accu_if.sv
// Window-in / result-out handshake bundle plus tile configuration and status.
interface conv_cin_tile_accu_if #(
  parameter int CIN  = 4,
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int ACCW = 24,
  parameter int OW   = 8
);
  logic                       start;
  logic                       win_valid;
  logic                       win_ready;
  logic [CIN*9*DW-1:0]        win_data;
  logic [CIN*9*WW-1:0]        weight;
  logic signed [ACCW-1:0]     bias;
  logic [4:0]                 shift;
  logic                       relu_en;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [OW-1:0]       dout;
  logic                       busy;
  logic                       done;

  // Driver side (window generator, configuration and downstream sink).
  modport master (
    output start, win_valid, win_data, weight, bias, shift, relu_en, out_ready,
    input  win_ready, out_valid, dout, busy, done
  );

  // Accumulator side.
  modport slave (
    input  start, win_valid, win_data, weight, bias, shift, relu_en, out_ready,
    output win_ready, out_valid, dout, busy, done
  );
endinterface

// File: rtl/conv_cin_tile_accu_dot.sv
// Two-stage pipelined CIN*9 multiply (S1) and adder tree (S2); side-band metadata
// travels alongside the data. Whole pipe holds while en_i is low.
module conv_cin_tile_accu_dot #(
  parameter int CIN  = 4,
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int ACCW = 24,
  parameter int MW   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [CIN*9*DW-1:0]    win_i,
  input  logic [CIN*9*WW-1:0]    wgt_i,
  input  logic [MW-1:0]          meta_i,
  output logic                   valid_o,
  output logic signed [ACCW-1:0] sum_o,
  output logic [MW-1:0]          meta_o,
  output logic                   occ_o
);
  localparam int NT = CIN * 9;
  localparam int PW = DW + WW;

  logic signed [PW-1:0]   prod_q [NT];
  logic                   s1_valid_q;
  logic [MW-1:0]          s1_meta_q;
  logic signed [ACCW-1:0] tree_c;
  logic signed [ACCW-1:0] sum_q;
  logic                   s2_valid_q;
  logic [MW-1:0]          s2_meta_q;

  // S1: register every tap product.
  // NOTE: clocked state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_meta_q  <= '0;
      for (int i = 0; i < NT; i++) prod_q[i] <= '0;
    end else if (en_i) begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_meta_q <= meta_i;
        for (int i = 0; i < NT; i++)
          prod_q[i] <= $signed(win_i[i*DW +: DW]) * $signed(wgt_i[i*WW +: WW]);
      end
    end
  end

  // Adder tree over the sign-extended products.
  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tree_c = '0;
    for (int i = 0; i < NT; i++) tree_c = tree_c + ACCW'(prod_q[i]);
  end

  // S2: register the window dot product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_meta_q  <= '0;
      sum_q      <= '0;
    end else if (en_i) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_meta_q <= s1_meta_q;
        sum_q     <= tree_c;
      end
    end
  end

  assign valid_o = s2_valid_q;
  assign sum_o   = sum_q;
  assign meta_o  = s2_meta_q;
  assign occ_o   = s1_valid_q | s2_valid_q;
endmodule

// File: rtl/conv_cin_tile_accu.sv
// Channel-tiled 3x3 conv accumulator: per-window dot product accumulated over NPASS
// channel groups into DEPTH pixel entries, quantised on the last pass.
module conv_cin_tile_accu #(
  parameter int CIN   = 4,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACCW  = 24,
  parameter int DEPTH = 16,
  parameter int NPASS = 2,
  parameter int OW    = 8
) (
  input logic               clk,
  input logic               rst_n,
  conv_cin_tile_accu_if.slave bus
);
  import conv_cin_tile_accu_pkg::*;

  localparam int AW = cnt_w(DEPTH);
  localparam int PW = cnt_w(NPASS);
  localparam int MW = AW + 2;   // {addr, first pass, last pass}

  state_e                 state_q;
  logic [AW-1:0]          addr_q;
  logic [PW-1:0]          pass_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   stall;
  logic                   win_ready_c;
  logic                   accept;
  logic [MW-1:0]          meta_in;

  logic                   s2_valid;
  logic signed [ACCW-1:0] s2_sum;
  logic [MW-1:0]          s2_meta;
  logic [AW-1:0]          s2_addr;
  logic                   s2_first;
  logic                   s2_last;
  logic                   pipe_occ;

  logic signed [ACCW-1:0] acc_q [DEPTH];
  logic signed [ACCW-1:0] total_c;
  logic                   s3_valid_q;
  logic signed [ACCW-1:0] s3_v_q;

  logic                   out_valid_q;
  logic signed [OW-1:0]   dout_q;
  logic                   drain_done;

  // A result waiting on downstream freezes every stage together.
  assign stall       = out_valid_q & ~bus.out_ready;
  assign win_ready_c = (state_q == RUN) & ~stall;
  assign accept      = bus.win_valid & win_ready_c;
  assign meta_in     = {addr_q, (pass_q == '0), (pass_q == PW'(NPASS - 1))};

  // Tile sequencing: address/pass counters, busy and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          addr_q  <= '0;
          pass_q  <= '0;
        end
        RUN: if (accept) begin
          if (addr_q == AW'(DEPTH - 1)) begin
            addr_q <= '0;
            if (pass_q == PW'(NPASS - 1)) begin
              pass_q  <= '0;
              state_q <= DRAIN;
            end else begin
              pass_q <= pass_q + PW'(1);
            end
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        DRAIN: if (drain_done) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  conv_cin_tile_accu_dot #(
    .CIN (CIN),
    .DW  (DW),
    .WW  (WW),
    .ACCW(ACCW),
    .MW  (MW)
  ) u_dot (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (~stall),
    .valid_i(accept),
    .win_i  (bus.win_data),
    .wgt_i  (bus.weight),
    .meta_i (meta_in),
    .valid_o(s2_valid),
    .sum_o  (s2_sum),
    .meta_o (s2_meta),
    .occ_o  (pipe_occ)
  );

  assign {s2_addr, s2_first, s2_last} = s2_meta;

  // Pass 0 starts the pixel fresh; later passes add onto the stored partial sum.
  always_comb begin
    total_c = s2_sum;
    if (!s2_first) total_c = acc_q[s2_addr] + s2_sum;
  end

  // S3 accumulator write-back.
  // NOTE: the accumulator array has no reset; pass 0 overwrites each entry before it is read.
  always_ff @(posedge clk) begin
    if (!stall && s2_valid) acc_q[s2_addr] <= total_c;
  end

  // S3 result register: only last-pass pixels move on, with bias folded in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_v_q     <= '0;
    end else if (!stall) begin
      s3_valid_q <= s2_valid & s2_last;
      if (s2_valid && s2_last) s3_v_q <= total_c + bus.bias;
    end
  end

  // Output register: round, saturate, ReLU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else if (!stall) begin
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) dout_q <= OW'(round_sat(64'(s3_v_q), bus.shift, OW, bus.relu_en));
    end
  end

  // The final result is handed off with nothing left behind it in the pipe.
  assign drain_done = ~pipe_occ & ~s3_valid_q & out_valid_q & bus.out_ready;

  assign bus.win_ready = win_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_conv_cin_tile_accu.sv
// Self-checking bench: directed and randomized tiles scored against a plain-arithmetic model.
module tb_conv_cin_tile_accu;
  localparam int CIN   = 2;
  localparam int DW    = 8;
  localparam int WW    = 8;
  localparam int ACCW  = 24;
  localparam int DEPTH = 4;
  localparam int NPASS = 2;
  localparam int OW    = 8;
  localparam int NT    = CIN * 9;
  localparam int NWIN  = DEPTH * NPASS;
  localparam int WB    = NT * DW;
  localparam int KB    = NT * WW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_cin_tile_accu_if #(.CIN(CIN), .DW(DW), .WW(WW), .ACCW(ACCW), .OW(OW)) bus ();

  conv_cin_tile_accu #(
    .CIN(CIN), .DW(DW), .WW(WW), .ACCW(ACCW), .DEPTH(DEPTH), .NPASS(NPASS), .OW(OW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [WB-1:0]        win_mem [NWIN];
  logic [KB-1:0]        wgt_mem [NWIN];
  logic signed [OW-1:0] exp_val [DEPTH];
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Reference: window dot product as a plain sum over channels and taps.
  function automatic longint dot(input logic [WB-1:0] w, input logic [KB-1:0] k);
    longint s = 0;
    for (int c = 0; c < CIN; c++)
      for (int t = 0; t < 9; t++)
        s += longint'($signed(w[(c*9+t)*DW +: DW])) * longint'($signed(k[(c*9+t)*WW +: WW]));
    return s;
  endfunction

  // Reference: floor((v + half) / 2^sh), clamp to OW bits, optional ReLU.
  function automatic logic signed [OW-1:0] quant(input longint v, input int sh, input bit relu);
    longint den, num, q, hi, lo;
    if (sh == 0) q = v;
    else begin
      den = longint'(1) << sh;
      num = v + den / 2;
      q   = num / den;
      if (num < 0 && (num % den) != 0) q = q - 1;
    end
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    if (relu && q < 0) q = 0;
    return OW'(q);
  endfunction

  // Window whose dot product with all-ones weights equals x.
  function automatic logic [WB-1:0] spread(input int x);
    logic [WB-1:0] v;
    int rem, t;
    v = '0;
    rem = x;
    for (int i = 0; i < NT; i++) begin
      t = (rem > 100) ? 100 : ((rem < -100) ? -100 : rem);
      v[i*DW +: DW] = DW'(t);
      rem -= t;
    end
    return v;
  endfunction

  function automatic logic [KB-1:0] ones();
    logic [KB-1:0] k;
    for (int i = 0; i < NT; i++) k[i*WW +: WW] = WW'(1);
    return k;
  endfunction

  task automatic set_pass(input int p, input int x0, input int x1, input int x2, input int x3);
    int xs [4];
    xs = '{x0, x1, x2, x3};
    for (int a = 0; a < DEPTH; a++) begin
      win_mem[p*DEPTH+a] = spread(xs[a % 4]);
      wgt_mem[p*DEPTH+a] = ones();
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NWIN; i++)
      for (int t = 0; t < NT; t++) begin
        win_mem[i][t*DW +: DW] = DW'($urandom);
        wgt_mem[i][t*WW +: WW] = WW'($urandom);
      end
  endtask

  task automatic compute_expected(input longint bias, input int sh, input bit relu);
    longint acc;
    for (int a = 0; a < DEPTH; a++) begin
      acc = 0;
      for (int p = 0; p < NPASS; p++) acc += dot(win_mem[p*DEPTH+a], wgt_mem[p*DEPTH+a]);
      exp_val[a] = quant(acc + bias, sh, relu);
    end
  endtask

  // One full tile. ready_mode: 0 always ready, 1 random, 2 five low cycles after first result.
  task automatic run_tile(input string tag, input longint bias, input int sh, input bit relu,
                          input int ready_mode, input bit gaps);
    int wi, got, cyc, low_cnt, first_ov, lp_cyc;
    compute_expected(bias, sh, relu);
    bus.bias    = ACCW'(bias);
    bus.shift   = 5'(sh);
    bus.relu_en = relu;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check({tag, " busy after start"}, 32'(bus.busy), 1);
    wi = 0; got = 0; cyc = 0; low_cnt = 0; first_ov = -1; lp_cyc = -1;
    while (got < DEPTH && cyc < 500) begin
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (got >= 1 && low_cnt < 5) begin
            bus.out_ready = 1'b0;
            low_cnt++;
          end else bus.out_ready = 1'b1;
        end
      endcase
      bus.win_valid = (wi < NWIN) && (!gaps || $urandom_range(0, 3) != 0);
      bus.win_data  = win_mem[wi % NWIN];
      bus.weight    = wgt_mem[wi % NWIN];
      #1;
      if (bus.out_valid && first_ov < 0) begin
        first_ov = cyc;
        check({tag, " no output before last pass"}, 32'(wi > (NPASS-1)*DEPTH), 1);
        check({tag, " latency"}, first_ov - lp_cyc, 4);
      end
      if (bus.out_valid && !bus.out_ready)
        check({tag, " win_ready low on stall"}, 32'(bus.win_ready), 0);
      if (bus.win_valid && bus.win_ready) begin
        if (wi == (NPASS-1)*DEPTH) lp_cyc = cyc;
        wi++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("%s dout[%0d]", tag, got), 32'(bus.dout), 32'(exp_val[got]));
        got++;
      end
      cyc++;
      if (got < DEPTH) @(negedge clk);
    end
    bus.win_valid = 1'b0;
    if (got < DEPTH) check({tag, " timeout results"}, got, DEPTH);
    check({tag, " windows accepted"}, wi, NWIN);
    @(negedge clk);
    #1;
    check({tag, " done pulse"}, 32'(bus.done), 1);
    check({tag, " busy cleared"}, 32'(bus.busy), 0);
    @(negedge clk);
    #1;
    check({tag, " done one cycle"}, 32'(bus.done), 0);
    check({tag, " no extra output"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    int wi, cyc;
    bus.start = 1'b0;
    bus.win_valid = 1'b0;
    bus.win_data = '0;
    bus.weight = '0;
    bus.bias = '0;
    bus.shift = '0;
    bus.relu_en = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset win_ready", 32'(bus.win_ready), 0);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset dout", 32'(bus.dout), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass 1 carries channel-0 taps of 2 with weights 1 (sum 18); shift 1 gives 9.
    set_pass(0, 0, 0, 0, 0);
    for (int a = 0; a < DEPTH; a++) begin
      win_mem[DEPTH+a] = '0;
      wgt_mem[DEPTH+a] = '0;
      for (int t = 0; t < 9; t++) begin
        win_mem[DEPTH+a][t*DW +: DW] = DW'(2);
        wgt_mem[DEPTH+a][t*WW +: WW] = WW'(1);
      end
    end
    run_tile("basic", 0, 1, 1'b0, 0, 1'b0);
    for (int a = 0; a < DEPTH; a++) check("basic model", 32'(exp_val[a]), 9);

    set_pass(0, 0, 0, 0, 0);
    set_pass(1, -3, 5, -4, 7);
    run_tile("round_sh1", 0, 1, 1'b0, 0, 1'b1);

    set_pass(0, 0, 0, 0, 0);
    set_pass(1, 17, -9, 0, 100);
    run_tile("round_sh0", 0, 0, 1'b0, 0, 1'b0);

    set_pass(0, 0, 0, 0, 0);
    set_pass(1, 200, -300, -5, 50);
    run_tile("sat", 0, 0, 1'b0, 0, 1'b0);
    run_tile("sat_relu", 0, 0, 1'b1, 0, 1'b0);

    set_pass(0, 10, -7, 0, 3);
    set_pass(1, 20, 4, -1, -3);
    run_tile("npass", 5, 0, 1'b0, 0, 1'b0);

    fill_random();
    run_tile("backpressure", 1000, 4, 1'b0, 2, 1'b1);

    // Reset in the middle of pass 1, then a fresh tile.
    fill_random();
    bus.bias = '0;
    bus.shift = 5'd0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wi = 0;
    cyc = 0;
    while (wi < DEPTH + 2 && cyc < 100) begin
      bus.out_ready = 1'b1;
      bus.win_valid = 1'b1;
      bus.win_data  = win_mem[wi];
      bus.weight    = wgt_mem[wi];
      #1;
      if (bus.win_valid && bus.win_ready) wi++;
      cyc++;
      @(negedge clk);
    end
    check("midreset reached pass 1", wi, DEPTH + 2);
    rst_n = 1'b0;
    bus.win_valid = 1'b0;
    #1;
    check("midreset win_ready", 32'(bus.win_ready), 0);
    check("midreset out_valid", 32'(bus.out_valid), 0);
    check("midreset dout", 32'(bus.dout), 0);
    check("midreset busy", 32'(bus.busy), 0);
    check("midreset done", 32'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    run_tile("after_reset", -300, 3, 1'b0, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      fill_random();
      run_tile($sformatf("rand%0d", r), longint'($urandom_range(0, 131071)) - 65536,
               int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 1, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
